// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared condition codes, flag indices and control-word layout
package pipe_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic       pcs;
      logic       reg_w;
      logic       mem_w;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic       no_write;
      logic [1:0] flag_w;
      logic [2:0] alu_control;
      cond_e      cond;
   } ctrl_t;

   // An all-zero word is a bubble: no write enables and an EQ condition.
   function automatic logic is_bubble(input ctrl_t c);
      return !(c.reg_w | c.mem_w | c.pcs | c.branch | (|c.flag_w));
   endfunction

endpackage

// File: rtl/pipe_cond_check.sv
// rtl/pipe_cond_check.sv - combinational evaluation of a condition field against NZCV
module pipe_cond_check
   import pipe_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      case (cond_e'(cond))
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = !z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = !c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = !n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = !v;
         COND_HI: cond_ex = c & !z;
         COND_LS: cond_ex = !c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = !z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_pipeline.sv
// rtl/pipe_ctrl_pipeline.sv - E/M/W control pipeline, NZCV owner and condition annulment
// Optional squash counter enabled by defining PIPE_SQUASH_CNT_EN.
module pipe_ctrl_pipeline
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       PCSD,
   input  logic       RegWD,
   input  logic       MemWD,
   input  logic       MemtoRegD,
   input  logic       ALUSrcD,
   input  logic       BranchD,
   input  logic       NoWriteD,
   input  logic [1:0] FlagWD,
   input  logic [2:0] ALUControlD,
   input  logic [3:0] CondD,
   input  logic       FlushE,
   input  logic [3:0] ALUFlags,
   output logic       ALUSrcE,
   output logic [2:0] ALUControlE,
   output logic       MemtoRegE,
   output logic       RegWriteM,
   output logic       MemtoRegW,
   output logic       BranchTakenE,
   output logic       PCSrcW,
   output logic       RegWriteW,
   output logic       MemWriteM,
   output logic [3:0] FlagsE
`ifdef PIPE_SQUASH_CNT_EN
   ,
   output logic [31:0] SquashCnt
`endif
);

   ctrl_t      d_ctrl;
   ctrl_t      e_q;
   logic [3:0] flags_q;
   logic       cond_ex;

   logic       pcs_ge;
   logic       reg_write_ge;
   logic       mem_write_ge;

   logic       pcs_m;
   logic       reg_write_m;
   logic       mem_write_m;
   logic       mem_to_reg_m;

   logic       pcs_w;
   logic       reg_write_w;
   logic       mem_to_reg_w;

   assign d_ctrl = '{
      pcs:         PCSD,
      reg_w:       RegWD,
      mem_w:       MemWD,
      mem_to_reg:  MemtoRegD,
      alu_src:     ALUSrcD,
      branch:      BranchD,
      no_write:    NoWriteD,
      flag_w:      FlagWD,
      alu_control: ALUControlD,
      cond:        cond_e'(CondD)
   };

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
      end else if (FlushE) begin
         e_q <= '0;
      end else begin
         e_q <= d_ctrl;
      end
   end

   pipe_cond_check u_cond_check (
      .cond    (e_q.cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   assign pcs_ge       = e_q.pcs & cond_ex;
   assign reg_write_ge = e_q.reg_w & cond_ex & !e_q.no_write;
   assign mem_write_ge = e_q.mem_w & cond_ex;

   // The two flag halves are written independently so ADDS-style and logical ops coexist.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else begin
         if (e_q.flag_w[1] & cond_ex) begin
            flags_q[FLAG_N] <= ALUFlags[FLAG_N];
            flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (e_q.flag_w[0] & cond_ex) begin
            flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            flags_q[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcs_m        <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         pcs_w        <= 1'b0;
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
      end else begin
         pcs_m        <= pcs_ge;
         reg_write_m  <= reg_write_ge;
         mem_write_m  <= mem_write_ge;
         mem_to_reg_m <= e_q.mem_to_reg;
         pcs_w        <= pcs_m;
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
      end
   end

`ifdef PIPE_SQUASH_CNT_EN
   logic [31:0] squash_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         squash_cnt_q <= 32'd0;
      end else if (!is_bubble(e_q) && !cond_ex) begin
         squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign SquashCnt = squash_cnt_q;
`endif

   assign ALUSrcE      = e_q.alu_src;
   assign ALUControlE  = e_q.alu_control;
   assign MemtoRegE    = e_q.mem_to_reg;
   assign BranchTakenE = e_q.branch & cond_ex;
   assign FlagsE       = flags_q;
   assign RegWriteM    = reg_write_m;
   assign MemWriteM    = mem_write_m;
   assign PCSrcW       = pcs_w;
   assign RegWriteW    = reg_write_w;
   assign MemtoRegW    = mem_to_reg_w;

endmodule

// File: tb/tb_pipe_ctrl_pipeline.sv
// tb/tb_pipe_ctrl_pipeline.sv - directed and randomized bench against a behavioural pipeline model
module tb_pipe_ctrl_pipeline;

   typedef struct packed {
      logic       pcs;
      logic       rw;
      logic       mw;
      logic       m2r;
      logic       src;
      logic       br;
      logic       nw;
      logic [1:0] fw;
      logic [2:0] alu;
      logic [3:0] cond;
   } instr_t;

   logic       clk;
   logic       rst_n;
   logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD;
   logic [1:0] FlagWD;
   logic [2:0] ALUControlD;
   logic [3:0] CondD;
   logic       FlushE;
   logic [3:0] ALUFlags;
   logic       ALUSrcE;
   logic [2:0] ALUControlE;
   logic       MemtoRegE, RegWriteM, MemtoRegW, BranchTakenE, PCSrcW, RegWriteW, MemWriteM;
   logic [3:0] FlagsE;
   logic [31:0] sq_obs;
`ifdef PIPE_SQUASH_CNT_EN
   logic [31:0] SquashCnt;
   assign sq_obs = SquashCnt;
`else
   assign sq_obs = 32'd0;
`endif

   pipe_ctrl_pipeline dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCSD         (PCSD),
      .RegWD        (RegWD),
      .MemWD        (MemWD),
      .MemtoRegD    (MemtoRegD),
      .ALUSrcD      (ALUSrcD),
      .BranchD      (BranchD),
      .NoWriteD     (NoWriteD),
      .FlagWD       (FlagWD),
      .ALUControlD  (ALUControlD),
      .CondD        (CondD),
      .FlushE       (FlushE),
      .ALUFlags     (ALUFlags),
      .ALUSrcE      (ALUSrcE),
      .ALUControlE  (ALUControlE),
      .MemtoRegE    (MemtoRegE),
      .RegWriteM    (RegWriteM),
      .MemtoRegW    (MemtoRegW),
      .BranchTakenE (BranchTakenE),
      .PCSrcW       (PCSrcW),
      .RegWriteW    (RegWriteW),
      .MemWriteM    (MemWriteM),
`ifdef PIPE_SQUASH_CNT_EN
      .SquashCnt    (SquashCnt),
`endif
      .FlagsE       (FlagsE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state
   instr_t      me;
   logic [3:0]  mflags;
   logic        m_pcs, m_rw, m_mw, m_m2r;
   logic        w_pcs, w_rw, w_m2r;
   logic [31:0] msq;

   // Condition rule: even code tests a predicate, odd code is its inverse; 1111 never.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      me = '0; mflags = '0; msq = '0;
      m_pcs = 0; m_rw = 0; m_mw = 0; m_m2r = 0;
      w_pcs = 0; w_rw = 0; w_m2r = 0;
   endtask

   task automatic model_edge();
      logic ok;
      ok = cond_ok(me.cond, mflags);
      if (me.fw[1] && ok) mflags[3:2] = ALUFlags[3:2];
      if (me.fw[0] && ok) mflags[1:0] = ALUFlags[1:0];
      if ((me.rw || me.mw || me.pcs || me.br || me.fw != 2'b00) && !ok) msq = msq + 32'd1;
      w_pcs = m_pcs; w_rw = m_rw; w_m2r = m_m2r;
      m_pcs = me.pcs && ok;
      m_rw  = me.rw && ok && !me.nw;
      m_mw  = me.mw && ok;
      m_m2r = me.m2r;
      if (FlushE) me = '0;
      else me = '{PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD, FlagWD, ALUControlD, CondD};
   endtask

   task automatic check_all();
      chk("ALUSrcE", 32'(ALUSrcE), 32'(me.src));
      chk("ALUControlE", 32'(ALUControlE), 32'(me.alu));
      chk("MemtoRegE", 32'(MemtoRegE), 32'(me.m2r));
      chk("BranchTakenE", 32'(BranchTakenE), 32'(me.br && cond_ok(me.cond, mflags)));
      chk("FlagsE", 32'(FlagsE), 32'(mflags));
      chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
      chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
      chk("PCSrcW", 32'(PCSrcW), 32'(w_pcs));
      chk("RegWriteW", 32'(RegWriteW), 32'(w_rw));
      chk("MemtoRegW", 32'(MemtoRegW), 32'(w_m2r));
`ifdef PIPE_SQUASH_CNT_EN
      chk("SquashCnt", sq_obs, msq);
`endif
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_outs"}, {20'd0, ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE, RegWriteM,
                           MemWriteM, PCSrcW, RegWriteW, MemtoRegW, FlagsE}, 32'd0);
      chk({tag, "_sq"}, sq_obs, 32'd0);
   endtask

   task automatic drive(input instr_t i, input logic flush, input logic [3:0] af);
      {PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD, FlagWD, ALUControlD, CondD} = i;
      FlushE = flush;
      ALUFlags = af;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_zero(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic instr_t mk(input logic [3:0] cond, input logic [1:0] fw,
                                 input logic rw, input logic mw, input logic pcs,
                                 input logic br, input logic nw);
      instr_t i;
      i = '0;
      i.cond = cond; i.fw = fw; i.rw = rw; i.mw = mw; i.pcs = pcs; i.br = br; i.nw = nw;
      return i;
   endfunction

   initial begin
      instr_t nop;
      nop = '0;
      rst_n = 1'b0;
      drive(nop, 1'b0, 4'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_zero("reset_initial");
      rst_n = 1'b1;

      // CMP then BEQ
      drive(mk(4'b1110, 2'b11, 0, 0, 0, 0, 0), 1'b0, 4'h0);
      cycle();
      drive(mk(4'b0000, 2'b00, 0, 0, 0, 1, 0), 1'b0, 4'b0100);
      cycle();
      chk("cmp_beq_flags", 32'(FlagsE), 32'h4);
      chk("cmp_beq_taken", 32'(BranchTakenE), 32'h1);

      // Failed condition squashes writes
      do_reset("reset_mid");
      drive(mk(4'b0000, 2'b00, 1, 1, 0, 0, 0), 1'b0, 4'h0);
      cycle();
      drive(nop, 1'b0, 4'h0);
      cycle();
      chk("fail_regwm", 32'(RegWriteM), 32'h0);
      chk("fail_memwm", 32'(MemWriteM), 32'h0);
`ifdef PIPE_SQUASH_CNT_EN
      chk("fail_squash", sq_obs, 32'd1);
`endif
      cycle();
      chk("fail_regww", 32'(RegWriteW), 32'h0);

      // NoWrite compare still updates flags
      drive(mk(4'b1110, 2'b11, 1, 0, 0, 0, 1), 1'b0, 4'h0);
      cycle();
      drive(nop, 1'b0, 4'b1010);
      cycle();
      chk("nowrite_regwm", 32'(RegWriteM), 32'h0);
      chk("nowrite_flags", 32'(FlagsE), 32'hA);

      // Flush turns the E slot into a bubble
      drive(mk(4'b1110, 2'b00, 1, 0, 1, 0, 0), 1'b1, 4'h0);
      cycle();
      drive(nop, 1'b0, 4'h0);
      cycle();
      cycle();
      chk("flush_pcsw", 32'(PCSrcW), 32'h0);
      chk("flush_regww", 32'(RegWriteW), 32'h0);

      // Partial flag write
      drive(mk(4'b1110, 2'b11, 0, 0, 0, 0, 0), 1'b0, 4'h0);
      cycle();
      drive(mk(4'b1110, 2'b10, 0, 0, 0, 0, 0), 1'b0, 4'b1111);
      cycle();
      chk("partial_set", 32'(FlagsE), 32'hF);
      drive(nop, 1'b0, 4'b0000);
      cycle();
      chk("partial_nz", 32'(FlagsE), 32'h3);

      // Unconditional write reaches W two edges after E
      drive(mk(4'b1110, 2'b00, 1, 0, 1, 0, 0), 1'b0, 4'h0);
      cycle();
      drive(nop, 1'b0, 4'h0);
      cycle();
      cycle();
      chk("al_pcsw", 32'(PCSrcW), 32'h1);
      chk("al_regww", 32'(RegWriteW), 32'h1);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         instr_t r;
         r = instr_t'($urandom);
         drive(r, ($urandom_range(0, 7) == 0), 4'($urandom));
         if ($urandom_range(0, 99) == 0) do_reset("reset_rand");
         else cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
